// File: rtl/numero_pkg.sv
// Shared definitions for the digit-grid sampler.
//   N_CELULAS : cells per grid side
//   PIXEL_W   : grey-level width
//   grade_t   : full 11x11 grid of 8-bit cells, indexed [row][column]
//   linha_t   : one grid row of 11 cells
//   estado_t  : capture FSM state
package numero_pkg;

    localparam int unsigned N_CELULAS = 11;
    localparam int unsigned PIXEL_W   = 8;

    typedef logic [N_CELULAS-1:0][N_CELULAS-1:0][PIXEL_W-1:0] grade_t;
    typedef logic [N_CELULAS-1:0][PIXEL_W-1:0]                linha_t;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        ARMADO  = 2'd1,
        CAPTURA = 2'd2
    } estado_t;

endpackage

// File: rtl/acumulador_coluna.sv
// Bank of 11 cell accumulators, one per grid column.
//   clk, reset  : clock, asynchronous active-high reset
//   reiniciar   : discard the stored sums before adding this cycle's pixel
//   somar       : add pixel into accumulator `coluna`
//   descarregar : clear all accumulators after this cycle (row flush)
//   coluna      : target column for the add
//   pixel       : grey level to add
//   medias      : per-column average including this cycle's add (truncating)
module acumulador_coluna
    import numero_pkg::*;
#(
    parameter int unsigned LOG_CELL = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                reiniciar,
    input  logic                                somar,
    input  logic                                descarregar,
    input  logic [3:0]                          coluna,
    input  logic [PIXEL_W-1:0]                  pixel,
    output logic [N_CELULAS-1:0][PIXEL_W-1:0]   medias
);

    // A cell holds at most 2^(2*LOG_CELL) pixels of 255, so this never overflows.
    localparam int unsigned ACC_W = PIXEL_W + 2 * LOG_CELL;

    logic [N_CELULAS-1:0][ACC_W-1:0] acc_q;
    logic [N_CELULAS-1:0][ACC_W-1:0] soma;

    always_comb begin
        for (int i = 0; i < N_CELULAS; i++) begin
            soma[i] = reiniciar ? '0 : acc_q[i];
            if (somar && coluna == 4'(i)) begin
                soma[i] = soma[i] + ACC_W'(pixel);
            end
            // Dividing by the cell area is just dropping the low bits.
            medias[i] = soma[i][2*LOG_CELL +: PIXEL_W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else if (descarregar) begin
            acc_q <= '0;
        end else begin
            acc_q <= soma;
        end
    end

endmodule

// File: rtl/amostrador_numero.sv
// Captures an 11x11 grid of box-averaged grey levels from a raster pixel stream.
//   clk, reset    : clock, asynchronous active-high reset
//   inicio        : one-cycle request to capture the next full window
//   pixel         : grey level
//   pixel_valido  : pixel/x/y valid this cycle
//   x, y          : raster coordinates of pixel
//   numero        : captured grid [row][column], changes only on completion
//   pronto        : one-cycle pulse, numero was just updated
//   ocupado       : capture armed or in progress
module amostrador_numero
    import numero_pkg::*;
#(
    parameter int unsigned X0       = 300,
    parameter int unsigned Y0       = 220,
    parameter int unsigned LOG_CELL = 2,
    parameter int unsigned COORD_W  = 10,
    parameter bit          INVERTER = 1'b0
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic                                             inicio,
    input  logic [PIXEL_W-1:0]                               pixel,
    input  logic                                             pixel_valido,
    input  logic [COORD_W-1:0]                               x,
    input  logic [COORD_W-1:0]                               y,
    output logic [N_CELULAS-1:0][N_CELULAS-1:0][PIXEL_W-1:0] numero,
    output logic                                             pronto,
    output logic                                             ocupado
);

    localparam int unsigned CELL = 1 << LOG_CELL;
    localparam int unsigned WIN  = N_CELULAS * CELL;

    estado_t estado_q, estado_d;
    grade_t  sombra_q;
    grade_t  grade_final;
    linha_t  medias;
    linha_t  linha_nova;

    logic [31:0] xe, ye, dx, dy;
    logic [3:0]  coluna, linha;
    logic        dentro, origem, fim_linha, fim_janela;
    logic        reiniciar, somar, descarregar, concluir;

    // Coordinate decode in 32 bits so window bounds never wrap.
    assign xe = 32'(x);
    assign ye = 32'(y);
    assign dx = xe - X0;
    assign dy = ye - Y0;

    assign dentro     = (xe >= X0) && (xe < X0 + WIN) && (ye >= Y0) && (ye < Y0 + WIN);
    assign coluna     = 4'(dx >> LOG_CELL);
    assign linha      = 4'(dy >> LOG_CELL);
    assign origem     = pixel_valido && (xe == X0) && (ye == Y0);
    assign fim_linha  = pixel_valido && dentro && (xe == X0 + WIN - 1)
                        && ((dy & 32'(CELL - 1)) == 32'(CELL - 1));
    assign fim_janela = fim_linha && (ye == Y0 + WIN - 1);

    acumulador_coluna #(
        .LOG_CELL (LOG_CELL)
    ) u_acumulador (
        .clk         (clk),
        .reset       (reset),
        .reiniciar   (reiniciar),
        .somar       (somar),
        .descarregar (descarregar),
        .coluna      (coluna),
        .pixel       (pixel),
        .medias      (medias)
    );

    always_comb begin
        for (int i = 0; i < N_CELULAS; i++) begin
            linha_nova[i] = INVERTER ? (8'hff - medias[i]) : medias[i];
        end
        // The last cell row never passes through the shadow before the output update.
        grade_final                = sombra_q;
        grade_final[N_CELULAS-1]   = linha_nova;
    end

    always_comb begin
        estado_d    = estado_q;
        reiniciar   = 1'b0;
        somar       = 1'b0;
        descarregar = 1'b0;
        concluir    = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (inicio) estado_d = ARMADO;
            end
            ARMADO: begin
                if (origem) begin
                    reiniciar = 1'b1;
                    somar     = 1'b1;
                    estado_d  = CAPTURA;
                end
            end
            CAPTURA: begin
                if (origem) begin
                    // New frame before the window finished: start over.
                    reiniciar = 1'b1;
                    somar     = 1'b1;
                end else if (pixel_valido && dentro) begin
                    somar       = 1'b1;
                    descarregar = fim_linha;
                    if (fim_janela) begin
                        concluir = 1'b1;
                        estado_d = OCIOSO;
                    end
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= OCIOSO;
            sombra_q <= '0;
            numero   <= '0;
            pronto   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            pronto   <= concluir;
            if (reiniciar) begin
                sombra_q <= '0;
            end else if (descarregar) begin
                sombra_q[linha] <= linha_nova;
            end
            if (concluir) begin
                numero <= grade_final;
            end
        end
    end

    assign ocupado = (estado_q != OCIOSO);

endmodule

// File: tb/tb_amostrador_numero.sv
// Directed bench for amostrador_numero: only the rows/columns around the window
// are streamed, each line preceded by an invalid cycle carrying origin coordinates.
module tb_amostrador_numero;
    import numero_pkg::*;

    localparam int X0  = 300;
    localparam int Y0  = 220;
    localparam int WIN = 44;
    localparam int XA  = X0 - 2;
    localparam int XB  = X0 + WIN + 1;
    localparam int YA  = Y0 - 2;
    localparam int YB  = Y0 + WIN + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       inicio;
    logic [7:0] pixel;
    logic       pixel_valido;
    logic [9:0] x, y;
    grade_t     numero, numero_inv;
    logic       pronto, pronto_inv, ocupado, ocupado_inv;

    int n_checks = 0;
    int n_pass   = 0;
    int npronto  = 0;
    int p0;

    always #5 clk = ~clk;

    always @(negedge clk) if (pronto === 1'b1) npronto++;

    amostrador_numero #(
        .X0 (X0), .Y0 (Y0), .LOG_CELL (2), .COORD_W (10), .INVERTER (1'b0)
    ) dut (
        .clk (clk), .reset (reset), .inicio (inicio), .pixel (pixel),
        .pixel_valido (pixel_valido), .x (x), .y (y),
        .numero (numero), .pronto (pronto), .ocupado (ocupado)
    );

    amostrador_numero #(
        .X0 (X0), .Y0 (Y0), .LOG_CELL (2), .COORD_W (10), .INVERTER (1'b1)
    ) dut_inv (
        .clk (clk), .reset (reset), .inicio (inicio), .pixel (pixel),
        .pixel_valido (pixel_valido), .x (x), .y (y),
        .numero (numero_inv), .pronto (pronto_inv), .ocupado (ocupado_inv)
    );

    // mode 0 uniform v; 1 cell value 10r+c; 2 truncation cells; 3 outside 255 inside 0
    function automatic logic [7:0] pix(input int mode, input int v, input int xx, input int yy);
        int lx, ly, r, c;
        bit in_w;
        lx = xx - X0;
        ly = yy - Y0;
        in_w = (lx >= 0) && (lx < WIN) && (ly >= 0) && (ly < WIN);
        r = ly / 4;
        c = lx / 4;
        case (mode)
            0: return 8'(v);
            1: return in_w ? 8'(10 * r + c) : 8'd0;
            2: begin
                if (!in_w) return 8'd0;
                if (r == 0 && c == 0) return (lx == 0 && ly == 0) ? 8'd15 : 8'd0;
                if (r == 0 && c == 1) return (lx == 4 && ly == 0) ? 8'd0 : 8'd15;
                return 8'd255;
            end
            default: return in_w ? 8'd0 : 8'd255;
        endcase
    endfunction

    function automatic grade_t esperado(input int mode, input int v, input bit inv);
        grade_t g;
        int val;
        for (int r = 0; r < 11; r++) begin
            for (int c = 0; c < 11; c++) begin
                case (mode)
                    0: val = v;
                    1: val = 10 * r + c;
                    2: val = (r == 0 && c == 0) ? 0 : (r == 0 && c == 1) ? 14 : 255;
                    default: val = 0;
                endcase
                g[r][c] = inv ? 8'(255 - val) : 8'(val);
            end
        end
        return g;
    endfunction

    task automatic send_frame(input int mode, input int v, input int y_from, input int y_to,
                              input int ini_y);
        for (int yy = y_from; yy <= y_to; yy++) begin
            pixel_valido = 1'b0;
            x = 10'(X0);
            y = 10'(Y0);
            pixel = 8'hff;
            inicio = 1'b0;
            @(posedge clk); #1;
            for (int xx = XA; xx <= XB; xx++) begin
                pixel_valido = 1'b1;
                x = 10'(xx);
                y = 10'(yy);
                pixel = pix(mode, v, xx, yy);
                inicio = (yy == ini_y) && (xx == XA);
                @(posedge clk); #1;
            end
        end
        pixel_valido = 1'b0;
        inicio = 1'b0;
    endtask

    task automatic pulse_inicio();
        inicio = 1'b1;
        @(posedge clk); #1;
        inicio = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; inicio = 1'b0; pixel_valido = 1'b0; pixel = 8'h0; x = '0; y = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (numero !== '0) $display("FAIL reset_numero: got %h want 0", numero); else n_pass++;
        n_checks++;
        if (pronto !== 1'b0) $display("FAIL reset_pronto: got %b want 0", pronto); else n_pass++;
        n_checks++;
        if (ocupado !== 1'b0) $display("FAIL reset_ocupado: got %b want 0", ocupado); else n_pass++;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_uniform();
        grade_t e;
        p0 = npronto;
        pulse_inicio();
        n_checks++;
        if (ocupado !== 1'b1) $display("FAIL uniform_ocupado_rise: got %b want 1", ocupado);
        else n_pass++;
        send_frame(0, 100, YA, YB, -1);
        e = esperado(0, 100, 1'b0);
        n_checks++;
        if (numero !== e) $display("FAIL uniform_grid: got %h want %h", numero, e); else n_pass++;
        e = esperado(0, 100, 1'b1);
        n_checks++;
        if (numero_inv !== e) $display("FAIL uniform_inv_grid: got %h want %h", numero_inv, e);
        else n_pass++;
        n_checks++;
        if (npronto - p0 !== 1) $display("FAIL uniform_pronto_count: got %0d want 1", npronto - p0);
        else n_pass++;
        n_checks++;
        if (ocupado !== 1'b0) $display("FAIL uniform_ocupado_fall: got %b want 0", ocupado);
        else n_pass++;
    endtask

    task automatic test_cell_pattern();
        grade_t e;
        p0 = npronto;
        pulse_inicio();
        send_frame(1, 0, YA, Y0 + WIN - 2, -1);
        e = esperado(0, 100, 1'b0);
        n_checks++;
        if (numero !== e) $display("FAIL pattern_shadow_hidden: got %h want %h", numero, e);
        else n_pass++;
        n_checks++;
        if (ocupado !== 1'b1) $display("FAIL pattern_ocupado: got %b want 1", ocupado); else n_pass++;
        send_frame(1, 0, Y0 + WIN - 1, YB, -1);
        e = esperado(1, 0, 1'b0);
        n_checks++;
        if (numero !== e) $display("FAIL pattern_grid: got %h want %h", numero, e); else n_pass++;
        n_checks++;
        if (npronto - p0 !== 1) $display("FAIL pattern_pronto_count: got %0d want 1", npronto - p0);
        else n_pass++;
    endtask

    task automatic test_trunc_inv();
        grade_t e;
        pulse_inicio();
        send_frame(2, 0, YA, YB, -1);
        e = esperado(2, 0, 1'b0);
        n_checks++;
        if (numero !== e) $display("FAIL trunc_grid: got %h want %h", numero, e); else n_pass++;
        pulse_inicio();
        send_frame(0, 255, YA, YB, -1);
        e = esperado(0, 255, 1'b0);
        n_checks++;
        if (numero !== e) $display("FAIL full_scale_grid: got %h want %h", numero, e); else n_pass++;
        pulse_inicio();
        send_frame(0, 0, YA, YB, -1);
        e = esperado(0, 0, 1'b1);
        n_checks++;
        if (numero_inv !== e) $display("FAIL inv_zero_grid: got %h want %h", numero_inv, e);
        else n_pass++;
        e = esperado(0, 0, 1'b0);
        n_checks++;
        if (numero !== e) $display("FAIL zero_grid: got %h want %h", numero, e); else n_pass++;
    endtask

    task automatic test_isolation();
        grade_t e;
        numero_pkg::grade_t dummy;
        dummy = '0;
        // Leave a non-zero grid first so the isolation result is observable.
        pulse_inicio();
        send_frame(0, 9, YA, YB, -1);
        pulse_inicio();
        send_frame(3, 0, YA, YB, -1);
        e = esperado(3, 0, 1'b0);
        n_checks++;
        if (numero !== e) $display("FAIL isolation_grid: got %h want %h", numero, e); else n_pass++;
        p0 = npronto;
        send_frame(1, 0, YA, YB, Y0 + 5);
        n_checks++;
        if (npronto !== p0) $display("FAIL midframe_no_pronto: got %0d want %0d", npronto, p0);
        else n_pass++;
        n_checks++;
        if (ocupado !== 1'b1) $display("FAIL midframe_ocupado: got %b want 1", ocupado); else n_pass++;
        n_checks++;
        if (numero !== dummy) $display("FAIL midframe_grid_held: got %h want %h", numero, dummy);
        else n_pass++;
        send_frame(1, 0, YA, YB, -1);
        e = esperado(1, 0, 1'b0);
        n_checks++;
        if (numero !== e) $display("FAIL midframe_next_grid: got %h want %h", numero, e); else n_pass++;
        n_checks++;
        if (npronto - p0 !== 1) $display("FAIL midframe_pronto_count: got %0d want 1", npronto - p0);
        else n_pass++;
    endtask

    task automatic test_restart();
        grade_t e;
        pulse_inicio();
        send_frame(0, 200, YA, Y0 + 21, -1);
        p0 = npronto;
        send_frame(0, 50, YA, YB, Y0 + 10);
        e = esperado(0, 50, 1'b0);
        n_checks++;
        if (numero !== e) $display("FAIL restart_grid: got %h want %h", numero, e); else n_pass++;
        n_checks++;
        if (npronto - p0 !== 1) $display("FAIL restart_pronto_count: got %0d want 1", npronto - p0);
        else n_pass++;
        n_checks++;
        if (ocupado !== 1'b0) $display("FAIL restart_ocupado: got %b want 0", ocupado); else n_pass++;
    endtask

    task automatic test_reset_mid();
        grade_t e;
        pulse_inicio();
        send_frame(0, 33, YA, Y0 + 21, -1);
        reset = 1'b1;
        #2;
        n_checks++;
        if (numero !== '0) $display("FAIL midreset_numero: got %h want 0", numero); else n_pass++;
        n_checks++;
        if (ocupado !== 1'b0) $display("FAIL midreset_ocupado: got %b want 0", ocupado); else n_pass++;
        n_checks++;
        if (pronto !== 1'b0) $display("FAIL midreset_pronto: got %b want 0", pronto); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        p0 = npronto;
        send_frame(0, 33, Y0 + 22, YB, -1);
        n_checks++;
        if (npronto !== p0) $display("FAIL midreset_no_pronto: got %0d want %0d", npronto, p0);
        else n_pass++;
        n_checks++;
        if (ocupado !== 1'b0) $display("FAIL midreset_idle: got %b want 0", ocupado); else n_pass++;
        pulse_inicio();
        send_frame(0, 77, YA, YB, -1);
        e = esperado(0, 77, 1'b0);
        n_checks++;
        if (numero !== e) $display("FAIL midreset_next_grid: got %h want %h", numero, e); else n_pass++;
        n_checks++;
        if (npronto - p0 !== 1) $display("FAIL midreset_pronto_count: got %0d want 1", npronto - p0);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_cell_pattern();
        test_trunc_inv();
        test_isolation();
        test_restart();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
